// File: rtl/rca_seq_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rca_seq_adder
//
// Multi-cycle wide adder. A single 4-bit ripple-carry slice is reused over
// N = WIDTH/4 clock cycles, least-significant slice first, with the carry
// held in a register between slices. Valid/ready handshakes on both sides.
//
// Optional feature macro: SUB_EN
//   defined   : sub=1 at the input handshake computes a-b (opB = ~b, carry-in
//               forced to 1); cout=1 then means "no borrow".
//   undefined : sub is accepted on the port but ignored; always a+b+cin.
//
// Parameters:
//   WIDTH      operand/result width, multiple of 4, >= 4 (default 16)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand request
//   in_ready   high while idle; operands accepted on in_valid && in_ready
//   a, b       operands, sampled on the input handshake
//   cin        carry-in, sampled on the input handshake
//   sub        subtract request, sampled on the input handshake
//   out_valid  result available (held until out_ready)
//   out_ready  consumer accepts the result
//   sum        registered result
//   cout       registered final carry-out
// -----------------------------------------------------------------------------
module rca_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [KW-1:0]      k_r;
  logic               carry_r;
  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;

  logic               accept_s;
  logic               last_slice_s;
  logic [KW+1:0]      shift_s;
  logic [3:0]         slice_a_s;
  logic [3:0]         slice_b_s;
  logic [4:0]         slice_t_s;
  logic [WIDTH-1:0]   sum_nxt_s;
  logic [WIDTH-1:0]   opb_cap_s;
  logic               carry_cap_s;

  // Handshake outputs are pure decodes of the registered state.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;

  assign accept_s     = in_valid && (state_r == IDLE);
  assign last_slice_s = (k_r == K_LAST);

`ifdef SUB_EN
  // Subtraction is a + ~b + 1; cin is overridden in that case.
  assign opb_cap_s   = sub ? ~b : b;
  assign carry_cap_s = sub ? 1'b1 : cin;
`else
  logic unused_sub_s;
  assign unused_sub_s = sub;
  assign opb_cap_s    = b;
  assign carry_cap_s  = cin;
`endif

  // Single 4-bit ripple slice selected by k; sum slice merged into the result.
  always_comb begin
    shift_s   = {k_r, 2'b00};
    slice_a_s = 4'(opa_r >> shift_s);
    slice_b_s = 4'(opb_r >> shift_s);
    slice_t_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {4'b0000, carry_r};
    sum_nxt_s = (sum_r & ~(WIDTH'(4'hF) << shift_s))
              | (WIDTH'(slice_t_s[3:0]) << shift_s);
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_slice_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, per-slice accumulation and carry chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r     <= '0;
      carry_r <= 1'b0;
      opa_r   <= '0;
      opb_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            opa_r   <= a;
            opb_r   <= opb_cap_s;
            carry_r <= carry_cap_s;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            k_r     <= '0;
          end
        end
        RUN: begin
          sum_r   <= sum_nxt_s;
          carry_r <= slice_t_s[4];
          if (last_slice_s) begin
            cout_r <= slice_t_s[4];
          end else begin
            k_r <= k_r + KW'(1'b1);
          end
        end
        DONE: begin
          // Result held until the consumer takes it.
        end
        default: begin
          k_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_adder.sv
`timescale 1ns/1ps
// Self-checking bench for rca_seq_adder, WIDTH=16 (four slices).
module tb_rca_seq_adder;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;

  int n_cmp  = 0;
  int n_fail = 0;

  rca_seq_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs[8];

  // Reference: plain arithmetic on the whole words.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mcin, input logic msub);
`ifdef SUB_EN
    if (msub) return {1'b0, ma} + {1'b0, ~mb} + 17'd1;
`endif
    return {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue one operation from IDLE, check latency and result, optionally
  // hold out_ready low for 'hold' DONE cycles while pulsing in_valid.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic tcin, input logic tsub,
                        input logic [W-1:0] esum, input logic ecout, input int hold);
    int lat;
    logic ir_bad;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb2; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; ir_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) ir_bad = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("in_ready_low_run", 32'(ir_bad), 32'd0);
    chk("sum", 32'(sum), 32'(esum));
    chk("cout", 32'(cout), 32'(ecout));
    chk("in_ready_low_done", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'(esum));
      chk("bp_cout", 32'(cout), 32'(ecout));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W:0] r;
    logic       hs;
    int         cyc, acc1, acc2, nacc;
    logic [W:0] res_q[$];
    logic ov_seen;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0};
`ifdef SUB_EN
    vecs[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
    vecs[7] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
`else
    vecs[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0};
    vecs[7] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0};
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
             vecs[i].esum, vecs[i].ecout, 0);
    end

    // Backpressure: 3 DONE cycles with in_valid pulses, then a fresh op.
    run_op(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h0FFF + 16'h0001, 1'b0, 3);
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 0);

    // Randomized against the model.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      r = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, r[W-1:0], r[W], int'($urandom_range(0, 2)));
    end

    // Reset after two RUN cycles aborts the operation.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    ov_seen = 1'b0;
    repeat (8) begin
      if (out_valid !== 1'b0) ov_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_out_valid", 32'(ov_seen), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0);

    // Back-to-back: in_valid held, out_ready tied high.
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; acc1 = -1; acc2 = -1; nacc = 0;
    while (res_q.size() < 2 && cyc < 40) begin
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        nacc++;
        if (nacc == 1) begin
          acc1 = cyc;
          a = 16'hFFFE; b = 16'h0003; cin = 1'b1;
        end else begin
          acc2 = cyc;
          in_valid = 1'b0;
        end
      end
      if (out_valid === 1'b1) res_q.push_back({cout, sum});
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_interval", 32'(acc2 - acc1), 32'd6);
    chk("b2b_count", 32'(res_q.size()), 32'd2);
    if (res_q.size() == 2) begin
      r = model(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      chk("b2b_res0", 32'(res_q[0]), 32'(r));
      r = model(16'hFFFE, 16'h0003, 1'b1, 1'b0);
      chk("b2b_res1", 32'(res_q[1]), 32'(r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
